// File: rtl/cache_2way_fill.sv
// cache_2way_fill: 2-way set-associative, write-through, write-allocate cache
// with an integrated miss/fill FSM. One pipeline request per cycle; a miss
// stalls the pipeline while the victim block is refilled word by word.
module cache_2way_fill #(
    parameter int ADDR_WIDTH = 16,
    parameter int SET_BITS   = 6,
    parameter int WOFF_BITS  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [15:0]           req_wdata_i,
    output logic [15:0]           rsp_data_o,
    output logic                  stall_o,
    output logic                  mem_rd_req_o,
    output logic                  mem_wr_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [15:0]           mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [15:0]           mem_rdata_i,
    input  logic                  mem_rvalid_i
);

    localparam int TAG_W = ADDR_WIDTH - SET_BITS - WOFF_BITS - 1;
    localparam int SETS  = 2 ** SET_BITS;
    localparam int WORDS = 2 ** WOFF_BITS;
    localparam int CNT_W = WOFF_BITS + 1;
    localparam int IDX_W = SET_BITS + WOFF_BITS;

    typedef enum logic {IDLE, FILL} state_e;

    // Request address fields; bit 0 is the byte lane inside a 16-bit word.
    logic [TAG_W-1:0]     req_tag;
    logic [SET_BITS-1:0]  req_set;
    logic [WOFF_BITS-1:0] req_word;
    logic [IDX_W-1:0]     rd_idx;
    logic                 unused_addr_bit;

    assign req_tag         = req_addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign req_set         = req_addr_i[WOFF_BITS+SET_BITS:WOFF_BITS+1];
    assign req_word        = req_addr_i[WOFF_BITS:1];
    assign rd_idx          = {req_set, req_word};
    assign unused_addr_bit = req_addr_i[0];

    // Metadata and data arrays.
    logic [SETS-1:0]  valid0_q, valid1_q, lru_q;
    logic [TAG_W-1:0] tag0_q [SETS];
    logic [TAG_W-1:0] tag1_q [SETS];
    logic [15:0]      data0_q [SETS*WORDS];
    logic [15:0]      data1_q [SETS*WORDS];

    // FSM and fill bookkeeping.
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [TAG_W-1:0]  base_tag_q, base_tag_d;
    logic [SET_BITS-1:0] base_set_q, base_set_d;
    logic              victim_q, victim_d;

    logic hit0, hit1, hit;
    logic load_hit, store_go, fill_ret, fill_last;
    logic [IDX_W-1:0] fill_idx;

    assign hit0      = (state_q == IDLE) & valid0_q[req_set] & (tag0_q[req_set] == req_tag);
    assign hit1      = (state_q == IDLE) & valid1_q[req_set] & (tag1_q[req_set] == req_tag);
    assign hit       = hit0 | hit1;
    assign load_hit  = req_valid_i & ~req_we_i & hit;
    assign store_go  = req_valid_i & req_we_i & hit & mem_ready_i;
    assign fill_ret  = (state_q == FILL) & mem_rvalid_i;
    assign fill_last = fill_ret & (ret_cnt_q == CNT_W'(WORDS - 1));
    assign fill_idx  = {base_set_q, ret_cnt_q[WOFF_BITS-1:0]};
    assign mem_wdata_o = req_wdata_i;

    // Zero-latency read of the hitting way; zero for misses and stores.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rsp_data_o = '0;
        if (!req_we_i) begin
            if (hit0) begin
                rsp_data_o = data0_q[rd_idx];
            end else if (hit1) begin
                rsp_data_o = data1_q[rd_idx];
            end
        end
    end

    // Next-state, stall and memory-request generation.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        base_tag_d   = base_tag_q;
        base_set_d   = base_set_q;
        victim_d     = victim_q;
        stall_o      = 1'b0;
        mem_rd_req_o = 1'b0;
        mem_wr_req_o = 1'b0;
        mem_addr_o   = {req_addr_i[ADDR_WIDTH-1:1], 1'b0};
        unique case (state_q)
            IDLE: begin
                mem_wr_req_o = req_valid_i & req_we_i & hit;
                stall_o      = (req_valid_i & ~hit) | (req_valid_i & req_we_i & hit & ~mem_ready_i);
                if (req_valid_i && !hit) begin
                    base_tag_d  = req_tag;
                    base_set_d  = req_set;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    // Prefer an empty way; otherwise evict the least recently used one.
                    if (!valid0_q[req_set]) begin
                        victim_d = 1'b0;
                    end else if (!valid1_q[req_set]) begin
                        victim_d = 1'b1;
                    end else begin
                        victim_d = lru_q[req_set];
                    end
                    state_d = FILL;
                end
            end
            FILL: begin
                stall_o      = 1'b1;
                mem_rd_req_o = (issue_cnt_q < CNT_W'(WORDS));
                mem_addr_o   = {base_tag_q, base_set_q, issue_cnt_q[WOFF_BITS-1:0], 1'b0};
                if (mem_rd_req_o && mem_ready_i) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (mem_rvalid_i) begin
                    ret_cnt_d = ret_cnt_q + CNT_W'(1);
                    if (fill_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and fill bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            base_tag_q  <= '0;
            base_set_q  <= '0;
            victim_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_tag_q  <= base_tag_d;
            base_set_q  <= base_set_d;
            victim_q    <= victim_d;
        end
    end

    // Valid bits are set on the last fill return; LRU points away from the way just used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (fill_last) begin
                if (victim_q) valid1_q[base_set_q] <= 1'b1;
                else          valid0_q[base_set_q] <= 1'b1;
            end
            if (load_hit || store_go) begin
                lru_q[req_set] <= hit0;
            end
        end
    end

    // Tag and data storage: fill returns, final tag install, and store hits.
    always_ff @(posedge clk_i) begin
        // NOTE: storage arrays carry no reset; the valid bits alone make their contents meaningful.
        if (!rst_i) begin
            if (fill_ret) begin
                if (victim_q) data1_q[fill_idx] <= mem_rdata_i;
                else          data0_q[fill_idx] <= mem_rdata_i;
            end
            if (fill_last) begin
                if (victim_q) tag1_q[base_set_q] <= base_tag_q;
                else          tag0_q[base_set_q] <= base_tag_q;
            end
            if (store_go) begin
                if (hit1) data1_q[rd_idx] <= req_wdata_i;
                else      data0_q[rd_idx] <= req_wdata_i;
            end
        end
    end

endmodule
